// File: rtl/instr_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_stream_loader_pkg
//   Shared constants for the RISC-I instruction stream loader: instruction
//   width, instruction memory size, host count-field width, the load marker
//   bytes understood by the instruction memory, and the loader state encoding.
//   States are plain localparams so legacy code can match on the raw codes.
// -----------------------------------------------------------------------------
package instr_stream_loader_pkg;

    localparam int WORD_LEN      = 32;
    localparam int InstrMEM_SIZE = 64;
    localparam int CNT_W         = 16;

    // Top byte of the header / terminator words seen by the instruction memory.
    localparam logic [7:0] LOAD_START_BYTE = 8'hFE;
    localparam logic [7:0] LOAD_END_BYTE   = 8'hFF;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] S_IDLE = 3'd0;
    localparam logic [ST_W-1:0] S_CNT  = 3'd1;
    localparam logic [ST_W-1:0] S_RX   = 3'd2;
    localparam logic [ST_W-1:0] S_CHK  = 3'd3;  // only reachable with INSTR_LOADER_CHECKSUM_EN
    localparam logic [ST_W-1:0] S_HDR  = 3'd4;
    localparam logic [ST_W-1:0] S_DATA = 3'd5;
    localparam logic [ST_W-1:0] S_END  = 3'd6;

endpackage

// File: rtl/instr_stream_loader_buf.sv
// -----------------------------------------------------------------------------
// instr_loader_buf
//   DEPTH x WORD_LEN register file holding the received program until the
//   burst is emitted. One synchronous write port, one asynchronous read port.
//
// Ports:
//   i_CLK    clock
//   i_We     write enable
//   i_Waddr  write address
//   i_Wdata  write data
//   i_Raddr  read address
//   o_Rdata  read data (combinational from i_Raddr)
// -----------------------------------------------------------------------------
module instr_loader_buf #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                i_CLK,
    input  logic                i_We,
    input  logic [AW-1:0]       i_Waddr,
    input  logic [WORD_LEN-1:0] i_Wdata,
    input  logic [AW-1:0]       i_Raddr,
    output logic [WORD_LEN-1:0] o_Rdata
);

    logic [WORD_LEN-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; every word is written before it
    // is read, and leaving it out lets the array map onto plain RAM/flops.
    always_ff @(posedge i_CLK) begin
        if (i_We) begin
            mem[i_Waddr] <= i_Wdata;
        end
    end

    assign o_Rdata = mem[i_Raddr];

endmodule

// File: rtl/instr_stream_loader.sv
// -----------------------------------------------------------------------------
// instr_stream_loader
//   Receives a host byte stream (count N as CNT_W/8 bytes MSB first, then N
//   big-endian words), buffers the program, then emits one gapless burst to
//   the instruction memory: header word, N instruction words, terminator word.
//   A word whose top byte is the terminator marker, N==0 or N>DEPTH aborts
//   the frame with an o_Err pulse and nothing is emitted.
//
//   Optional feature, macro INSTR_LOADER_CHECKSUM_EN: one extra byte after the
//   data must equal the XOR of all count and data bytes before the burst.
//
// Ports:
//   i_CLK          clock
//   i_RSTN         asynchronous active-low reset
//   i_Byte         host data byte
//   i_Byte_Valid   one-cycle strobe qualifying i_Byte
//   o_Write_Instr  registered write stream to instruction memory
//   o_Busy         high from first count byte until the burst ends
//   o_Done         one-cycle pulse the cycle after the terminator
//   o_Err          one-cycle pulse on a protocol error
//
// CNT_W must be at least 16 and WORD_LEN a multiple of 8.
// -----------------------------------------------------------------------------
module instr_stream_loader #(
    parameter int WORD_LEN = instr_stream_loader_pkg::WORD_LEN,
    parameter int DEPTH    = instr_stream_loader_pkg::InstrMEM_SIZE,
    parameter int CNT_W    = instr_stream_loader_pkg::CNT_W
) (
    input  logic                i_CLK,
    input  logic                i_RSTN,
    input  logic [7:0]          i_Byte,
    input  logic                i_Byte_Valid,
    output logic [WORD_LEN-1:0] o_Write_Instr,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Err
);

    import instr_stream_loader_pkg::*;

    localparam int BYTES = WORD_LEN / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CB    = CNT_W / 8;
    localparam int CB_W  = (CB > 1) ? $clog2(CB) : 1;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [WORD_LEN-1:0] HDR_WORD = {LOAD_START_BYTE, {(WORD_LEN-8){1'b0}}};
    localparam logic [WORD_LEN-1:0] END_WORD = {LOAD_END_BYTE,   {(WORD_LEN-8){1'b0}}};

    logic [ST_W-1:0]     state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CB_W-1:0]     cb_q, cb_d;
    logic [WORD_LEN-1:0] asm_q, asm_d;
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [WORD_LEN-1:0] out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                buf_we;
    logic [WORD_LEN-1:0] rd_data;

    instr_loader_buf #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_buf (
        .i_CLK   (i_CLK),
        .i_We    (buf_we),
        .i_Waddr (wptr_q[AW-1:0]),
        .i_Wdata (asm_d),
        .i_Raddr (rptr_q[AW-1:0]),
        .o_Rdata (rd_data)
    );

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cb_d    = cb_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        busy_d  = busy_q;
        out_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        buf_we  = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_Byte_Valid) begin
                    count_d = CNT_W'(i_Byte);
                    cb_d    = CB_W'(1);
                    bcnt_d  = '0;
                    wptr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_CNT;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d  = i_Byte;
`endif
                end
            end

            S_CNT: begin
                if (i_Byte_Valid) begin
                    count_d = {count_q[CNT_W-9:0], i_Byte};
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ i_Byte;
`endif
                    if (cb_q == CB_W'(CB - 1)) begin
                        if (count_d == '0 || count_d > CNT_W'(DEPTH)) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_RX;
                        end
                    end else begin
                        cb_d = cb_q + CB_W'(1);
                    end
                end
            end

            S_RX: begin
                if (i_Byte_Valid) begin
                    asm_d = {asm_q[WORD_LEN-9:0], i_Byte};
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ i_Byte;
`endif
                    if (bcnt_q == BC_W'(BYTES - 1)) begin
                        bcnt_d = '0;
                        // A terminator-marked word would end the memory load early.
                        if (asm_d[WORD_LEN-1 -: 8] == LOAD_END_BYTE) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            wptr_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            buf_we = 1'b1;
                            wptr_d = wptr_q + PW'(1);
                            if (CNT_W'(wptr_d) == count_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                                state_d = S_CHK;
`else
                                // Header is registered on the same edge that
                                // takes the last byte: 1-cycle latency.
                                out_d   = HDR_WORD;
                                rptr_d  = '0;
                                state_d = S_HDR;
`endif
                            end
                        end
                    end else begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end
            end

`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (i_Byte_Valid) begin
                    if (i_Byte == csum_q) begin
                        out_d   = HDR_WORD;
                        rptr_d  = '0;
                        state_d = S_HDR;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        wptr_d  = '0;
                        state_d = S_IDLE;
                    end
                end
            end
`endif

            // The output register always carries the value for the next
            // cycle, so each state prepares what follows it.
            S_HDR: begin
                out_d   = rd_data;
                rptr_d  = rptr_q + PW'(1);
                state_d = S_DATA;
            end

            S_DATA: begin
                if (CNT_W'(rptr_q) == count_q) begin
                    out_d   = END_WORD;
                    state_d = S_END;
                end else begin
                    out_d  = rd_data;
                    rptr_d = rptr_q + PW'(1);
                end
            end

            S_END: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q <= S_IDLE;
            count_q <= '0;
            cb_q    <= '0;
            asm_q   <= '0;
            bcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cb_q    <= cb_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign o_Write_Instr = out_q;
    assign o_Busy        = busy_q;
    assign o_Done        = done_q;
    assign o_Err         = err_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_stream_loader
//   Directed bench for instr_stream_loader. Inputs change 1 ns after the rising
//   edge and outputs are sampled at that same point. A small model of the
//   downstream instruction memory captures what each burst writes.
//   Honors INSTR_LOADER_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_instr_stream_loader;

    localparam logic [31:0] HDR = 32'hFE00_0000;
    localparam logic [31:0] TRM = 32'hFF00_0000;

    logic        clk;
    logic        rstn;
    logic [7:0]  byte_in;
    logic        byte_vld;
    logic [31:0] wr_instr;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [31:0] words [64];

    instr_stream_loader dut (
        .i_CLK         (clk),
        .i_RSTN        (rstn),
        .i_Byte        (byte_in),
        .i_Byte_Valid  (byte_vld),
        .o_Write_Instr (wr_instr),
        .o_Busy        (busy),
        .o_Done        (done),
        .o_Err         (err)
    );

    always #5 clk = ~clk;

    // Downstream instruction memory: header starts a load at address 0,
    // terminator ends it, everything between is stored in order.
    logic [31:0] imem [64];
    logic        im_load;
    int          im_addr;
    int          hdr_cnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            im_load <= 1'b0;
            im_addr <= 0;
            for (int i = 0; i < 64; i++) imem[i] <= '0;
        end else if (im_load) begin
            if (wr_instr == TRM) begin
                im_load <= 1'b0;
            end else begin
                imem[im_addr % 64] <= wr_instr;
                im_addr <= im_addr + 1;
            end
        end else if (wr_instr == HDR) begin
            im_load <= 1'b1;
            im_addr <= 0;
        end
    end

    always @(posedge clk) begin
        if (wr_instr == HDR) hdr_cnt <= hdr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_in  = b;
        byte_vld = 1'b1;
        step();
        byte_vld = 1'b0;
        repeat (gap) step();
    endtask

    // mode 0: full frame; 1: no checksum byte; 2: corrupted checksum byte.
    task automatic send_frame(input int n, input int mode);
        logic [7:0]  q [$];
        logic [7:0]  cs;
        logic [15:0] nn;
        logic [31:0] w;
        nn = 16'(n);
        q.push_back(nn[15:8]);
        q.push_back(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            q.push_back(w[31:24]);
            q.push_back(w[23:16]);
            q.push_back(w[15:8]);
            q.push_back(w[7:0]);
        end
        cs = 8'h00;
        foreach (q[i]) cs = cs ^ q[i];
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (mode == 0) q.push_back(cs);
        if (mode == 2) q.push_back(~cs);
`else
        if (mode > 99) q.push_back(cs);
`endif
        foreach (q[i]) send_byte(q[i], (i == q.size() - 1) ? 0 : 1);
    endtask

    // Called right after the last frame byte: header must already be driven.
    task automatic expect_burst(input int n, input string tag);
        check({tag, " header"}, wr_instr, HDR);
        check({tag, " busy in burst"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s word %0d", tag, i), wr_instr, words[i]);
        end
        step();
        check({tag, " terminator"}, wr_instr, TRM);
        check({tag, " done low at terminator"}, 32'(done), 32'd0);
        step();
        check({tag, " idle out"}, wr_instr, 32'd0);
        check({tag, " done pulse"}, 32'(done), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        step();
        check({tag, " done cleared"}, 32'(done), 32'd0);
    endtask

    initial begin
        int hdr_before;
        clk      = 1'b0;
        rstn     = 1'b0;
        byte_in  = 8'h00;
        byte_vld = 1'b0;
        hdr_cnt  = 0;

        // Reset state
        #3;
        check("reset out", wr_instr, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        #14 rstn = 1'b1;
        step();

        // N=3 program with 1-cycle byte gaps
        words[0] = 32'h0050_0093;
        words[1] = 32'h00A0_0113;
        words[2] = 32'h0020_81B3;
        send_frame(3, 0);
        expect_burst(3, "n3");
        check("n3 imem0", imem[0], 32'h0050_0093);
        check("n3 imem1", imem[1], 32'h00A0_0113);
        check("n3 imem2", imem[2], 32'h0020_81B3);

        // Zero count
        hdr_before = hdr_cnt;
        send_byte(8'h00, 0);
        check("zero busy after 1st byte", 32'(busy), 32'd1);
        check("zero no err yet", 32'(err), 32'd0);
        send_byte(8'h00, 0);
        check("zero err", 32'(err), 32'd1);
        check("zero busy", 32'(busy), 32'd0);
        check("zero out", wr_instr, 32'd0);
        step();
        check("zero err one cycle", 32'(err), 32'd0);

        // Count 65 exceeds depth, then a valid N=1 frame
        send_byte(8'h00, 1);
        send_byte(8'h41, 0);
        check("over err", 32'(err), 32'd1);
        check("over busy", 32'(busy), 32'd0);
        step();
        check("no header after count errors", 32'(hdr_cnt - hdr_before), 32'd0);
        words[0] = 32'h0000_0013;
        send_frame(1, 0);
        expect_burst(1, "n1");
        check("n1 imem0", imem[0], 32'h0000_0013);

        // Terminator-marked data word aborts the frame
        hdr_before = hdr_cnt;
        words[0] = 32'h1122_3344;
        words[1] = 32'hFF00_1234;
        send_frame(2, 1);
        check("ff err", 32'(err), 32'd1);
        check("ff busy", 32'(busy), 32'd0);
        check("ff out", wr_instr, 32'd0);
        repeat (4) step();
        check("ff no header", 32'(hdr_cnt - hdr_before), 32'd0);
        check("ff out idle", wr_instr, 32'd0);

        // Full depth; word 5 carries a header-marked top byte, legal as data
        for (int i = 0; i < 64; i++) words[i] = 32'h0000_0013 | (32'(i) << 20);
        words[5] = 32'hFE00_0513;
        send_frame(64, 0);
        expect_burst(64, "n64");
        check("n64 imem5", imem[5], 32'hFE00_0513);
        check("n64 imem63", imem[63], 32'h03F0_0013);

        // Asynchronous reset in the middle of the data phase
        words[0] = 32'h0050_0093;
        words[1] = 32'h00A0_0113;
        words[2] = 32'h0020_81B3;
        send_frame(3, 0);
        check("rst header", wr_instr, HDR);
        step();
        step();
        check("rst mid data", wr_instr, 32'h00A0_0113);
        #2 rstn = 1'b0;
        #1;
        check("rst out", wr_instr, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h0000_0033;
        send_frame(2, 0);
        expect_burst(2, "after rst");
        check("after rst imem0", imem[0], 32'hDEAD_BEEF);
        check("after rst imem1", imem[1], 32'h0000_0033);
        check("after rst imem2 cleared", imem[2], 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Wrong checksum byte
        hdr_before = hdr_cnt;
        words[0] = 32'h0000_0013;
        send_frame(1, 2);
        check("csum err", 32'(err), 32'd1);
        check("csum busy", 32'(busy), 32'd0);
        check("csum out", wr_instr, 32'd0);
        repeat (4) step();
        check("csum no header", 32'(hdr_cnt - hdr_before), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
